// File: rtl/decode_pkg.sv
// Shared constants for the decode_scan select-line driver: mode encodings
// and default geometry.
package decode_pkg;

   localparam logic MODE_DIRECT = 1'b0;
   localparam logic MODE_SCAN   = 1'b1;

   localparam int SEL_W_DEF   = 4;
   localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/onehot_dec.sv
// Combinational SEL_W -> 2^SEL_W one-hot decoder with active-high enable.
// With en low every output is zero.
module onehot_dec
   import decode_pkg::*;
#(
   parameter int SEL_W = SEL_W_DEF
) (
   input  logic                    en,
   input  logic [SEL_W-1:0]        sel,
   output logic [(1<<SEL_W)-1:0]   dec
);

   // Single bit set at position sel when enabled.
   always_comb begin
      dec = '0;
      if (en) dec[sel] = 1'b1;
   end

endmodule

// File: rtl/decode_scan.sv
// Registered 1-of-2^SEL_W decoder with built-in scan sequencer.
// Direct mode decodes a loaded index; scan mode steps through every output,
// holding each for dwell+1 cycles, and pulses wrap on the roll-over.
// Optional build macro DECODE_SCAN_DIR_EN adds a dir input (1 = scan down).
module decode_scan
   import decode_pkg::*;
#(
   parameter int SEL_W   = SEL_W_DEF,
   parameter int DWELL_W = DWELL_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    en,
   input  logic                    mode,
   input  logic                    load,
   input  logic [SEL_W-1:0]        sel_in,
   input  logic [DWELL_W-1:0]      dwell,
`ifdef DECODE_SCAN_DIR_EN
   input  logic                    dir,
`endif
   output logic [(1<<SEL_W)-1:0]   out,
   output logic [SEL_W-1:0]        idx,
   output logic                    wrap
);

   localparam int N = 1 << SEL_W;

   logic [DWELL_W-1:0] cnt;
   logic               mode_q;
   logic [SEL_W-1:0]   idx_nxt;
   logic [DWELL_W-1:0] cnt_nxt;
   logic               wrap_nxt;
   logic               step_dn;
   logic [N-1:0]       dec;

`ifdef DECODE_SCAN_DIR_EN
   assign step_dn = dir;
`else
   assign step_dn = 1'b0;
`endif

   // Next index/count/wrap: load beats mode change beats scan stepping.
   always_comb begin
      idx_nxt  = idx;
      cnt_nxt  = cnt;
      wrap_nxt = 1'b0;
      if (load) begin
         idx_nxt = sel_in;
         cnt_nxt = '0;
      end else if (mode != mode_q) begin
         cnt_nxt = '0;
      end else if (mode == MODE_SCAN) begin
         if (cnt >= dwell) begin
            cnt_nxt = '0;
            if (step_dn) begin
               idx_nxt  = idx - SEL_W'(1);
               wrap_nxt = (idx == '0);
            end else begin
               idx_nxt  = idx + SEL_W'(1);
               wrap_nxt = (idx == SEL_W'(N - 1));
            end
         end else begin
            cnt_nxt = cnt + DWELL_W'(1);
         end
      end
   end

   // Decode the next index so the registered output never lags idx;
   // en low yields all-zero.
   onehot_dec #(.SEL_W(SEL_W)) u_dec (
      .en  (en),
      .sel (idx_nxt),
      .dec (dec)
   );

   // State register: state advances only when enabled, outputs clear when not.
   always_ff @(posedge clk) begin
      if (rst) begin
         idx    <= '0;
         cnt    <= '0;
         mode_q <= MODE_DIRECT;
         out    <= '0;
         wrap   <= 1'b0;
      end else begin
         out  <= dec;
         wrap <= en & wrap_nxt;
         if (en) begin
            idx    <= idx_nxt;
            cnt    <= cnt_nxt;
            mode_q <= mode;
         end
      end
   end

endmodule

// File: tb/tb_decode_scan.sv
// Scoreboard bench for decode_scan: stimulus pushes hand-computed
// expectations tagged with the cycle they apply to; a monitor on the
// falling edge pops and compares out/idx/wrap.
module tb_decode_scan;

   logic        clk = 1'b0;
   logic        rst, en, mode, load;
   logic [3:0]  sel_in;
   logic [7:0]  dwell;
   logic [15:0] out;
   logic [3:0]  idx;
   logic        wrap;
`ifdef DECODE_SCAN_DIR_EN
   logic        dir = 1'b0;
`endif

   decode_scan #(.SEL_W(4), .DWELL_W(8)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .mode   (mode),
      .load   (load),
      .sel_in (sel_in),
      .dwell  (dwell),
`ifdef DECODE_SCAN_DIR_EN
      .dir    (dir),
`endif
      .out    (out),
      .idx    (idx),
      .wrap   (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned cyc;
      logic [15:0] o;
      logic [3:0]  i;
      logic        w;
      string       name;
   } exp_t;

   exp_t        q[$];
   int unsigned cyc   = 0;
   int          nvec  = 0;
   int          nerr  = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: compare every expectation due at this cycle.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= cyc) begin
         exp_t e;
         e = q.pop_front();
         nvec++;
         if (e.cyc != cyc) begin
            nerr++;
            $display("FAIL %s: expectation for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
         end else if (out !== e.o || idx !== e.i || wrap !== e.w) begin
            nerr++;
            $display("FAIL %s @%0d: got out=%h idx=%0d wrap=%b, want out=%h idx=%0d wrap=%b",
                     e.name, cyc, out, idx, wrap, e.o, e.i, e.w);
         end
      end
   end

   // Queue the state expected after the coming edge, then take that edge.
   task automatic step(input string name, input logic [15:0] o,
                       input logic [3:0] i, input logic w);
      exp_t e;
      e.cyc = cyc + 1; e.o = o; e.i = i; e.w = w; e.name = name;
      q.push_back(e);
      @(posedge clk); #2;
   endtask

   function automatic logic [15:0] oh(input int k);
      logic [15:0] v;
      v = 16'h0001 << k;
      return v;
   endfunction

   initial begin
      rst = 1'b1; en = 1'b1; mode = 1'b1; load = 1'b0; sel_in = '0; dwell = 8'd2;
      @(posedge clk); #2;

      // Reset held two cycles with en=1, mode=1
      step("reset0", 16'h0000, 4'd0, 1'b0);
      step("reset1", 16'h0000, 4'd0, 1'b0);

      // Scan with dwell=2 from reset: 3 cycles per index, wrap at t=49
      rst = 1'b0;
      for (int t = 1; t <= 52; t++)
         step("scan_dwell2", oh(((t - 1) / 3) % 16), 4'(((t - 1) / 3) % 16), (t == 49));

      // Direct decode: load 0..15 on consecutive cycles
      mode = 1'b0; load = 1'b1;
      for (int s = 0; s < 16; s++) begin
         sel_in = 4'(s);
         step("direct_load", oh(s), 4'(s), 1'b0);
      end
      load = 1'b0;
      step("direct_hold", 16'h8000, 4'd15, 1'b0);

      // Load priority mid-scan: reach idx=5 cnt=2, then load 12
      mode = 1'b1; dwell = 8'd2; load = 1'b1; sel_in = 4'd5;
      step("lp_load5", oh(5), 4'd5, 1'b0);
      load = 1'b0;
      step("lp_cnt1", oh(5), 4'd5, 1'b0);
      step("lp_cnt2", oh(5), 4'd5, 1'b0);
      load = 1'b1; sel_in = 4'd12;
      step("lp_load12", oh(12), 4'd12, 1'b0);
      load = 1'b0;
      step("lp_resume1", oh(12), 4'd12, 1'b0);
      step("lp_resume2", oh(12), 4'd12, 1'b0);
      step("lp_adv13", oh(13), 4'd13, 1'b0);

      // Enable freeze at idx=7 cnt=1; load during freeze is ignored
      load = 1'b1; sel_in = 4'd7;
      step("fz_load7", oh(7), 4'd7, 1'b0);
      load = 1'b0;
      step("fz_cnt1", oh(7), 4'd7, 1'b0);
      en = 1'b0;
      for (int k = 0; k < 4; k++) begin
         load   = (k == 1);
         sel_in = 4'd3;
         step("fz_off", 16'h0000, 4'd7, 1'b0);
      end
      load = 1'b0; en = 1'b1;
      step("fz_back", 16'h0080, 4'd7, 1'b0);
      step("fz_adv8", oh(8), 4'd8, 1'b0);

      // Lowering dwell below cnt advances on the next edge
      step("dw_cnt1", oh(8), 4'd8, 1'b0);
      dwell = 8'd0;
      step("dw_lower", oh(9), 4'd9, 1'b0);
      step("dw0_a", oh(10), 4'd10, 1'b0);
      step("dw0_b", oh(11), 4'd11, 1'b0);

      // Mode change clears cnt and holds idx
      dwell = 8'd3;
      step("mc_cnt1", oh(11), 4'd11, 1'b0);
      step("mc_cnt2", oh(11), 4'd11, 1'b0);
      mode = 1'b0;
      step("mc_to_direct", oh(11), 4'd11, 1'b0);
      step("mc_direct_hold", oh(11), 4'd11, 1'b0);
      mode = 1'b1;
      step("mc_to_scan", oh(11), 4'd11, 1'b0);
      step("mc_c1", oh(11), 4'd11, 1'b0);
      step("mc_c2", oh(11), 4'd11, 1'b0);
      step("mc_c3", oh(11), 4'd11, 1'b0);
      step("mc_adv12", oh(12), 4'd12, 1'b0);

      // Wrap with dwell=0, and no wrap when a load lands on 0
      dwell = 8'd0; load = 1'b1; sel_in = 4'd15;
      step("wr_load15", oh(15), 4'd15, 1'b0);
      load = 1'b0;
      step("wr_wrap", 16'h0001, 4'd0, 1'b1);
      step("wr_after", 16'h0002, 4'd1, 1'b0);
      load = 1'b1; sel_in = 4'd15;
      step("wr_load15b", oh(15), 4'd15, 1'b0);
      sel_in = 4'd0;
      step("wr_load0_nowrap", 16'h0001, 4'd0, 1'b0);
      load = 1'b0;

      // Reset mid-scan, then recovery to out[0]
      step("rs_pre", 16'h0002, 4'd1, 1'b0);
      rst = 1'b1;
      step("rs_mid", 16'h0000, 4'd0, 1'b0);
      rst = 1'b0;
      step("rs_first", 16'h0001, 4'd0, 1'b0);
      step("rs_next", 16'h0002, 4'd1, 1'b0);

`ifdef DECODE_SCAN_DIR_EN
      // Down-scan from 1 with dwell=0: 1, 0, 15 (wrap), 14
      load = 1'b1; sel_in = 4'd1; dir = 1'b1;
      step("dir_load1", oh(1), 4'd1, 1'b0);
      load = 1'b0;
      step("dir_0", oh(0), 4'd0, 1'b0);
      step("dir_15", oh(15), 4'd15, 1'b1);
      step("dir_14", oh(14), 4'd14, 1'b0);
`endif

      // Drain the scoreboard with a bounded wait
      for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
      @(negedge clk); #1;
      if (q.size() > 0) begin
         nvec++;
         nerr++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
